// File: rtl/naive_design.sv
// Iterative SHA-256 compression core.
// Runs one round per clock over a caller-expanded 64-word schedule.
module naive_design #(
  parameter int ROUNDS = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:7][31:0] H_in,
  input  logic [0:63][31:0] W,
  output logic [0:255]     H_out,
  output logic             done
);

  localparam logic [6:0] LAST = 7'(ROUNDS);

  typedef enum logic {
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [0:7][31:0] hs;
  logic [6:0] t;
  logic [31:0] k, s0, s1, ch, maj, t1, t2;
  logic rnd, fin;

  always_ff @(posedge clk) begin
    if (reset) state <= S_RUN;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == S_RUN && t == LAST)
      state_nx = S_DONE;
  end

  always_comb begin
    rnd  = (state == S_RUN) && (t != LAST);
    fin  = (state == S_RUN) && (t == LAST);
    done = (state == S_DONE);
  end

  always_comb begin
    s0  = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
    s1  = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
    ch  = (e & f) ^ (~e & g);
    maj = (a & b) ^ (a & c) ^ (b & c);
    t1  = h + s1 + ch + k + W[t[5:0]];
    t2  = s0 + maj;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      {a, b, c, d, e, f, g, h} <= H_in;
      hs    <= H_in;
      t     <= '0;
      H_out <= '0;
    end else begin
      if (rnd) begin
        h <= g;
        g <= f;
        f <= e;
        e <= d + t1;
        d <= c;
        c <= b;
        b <= a;
        a <= t1 + t2;
        t <= t + 7'd1;
      end
      if (fin)
        H_out <= {hs[0] + a, hs[1] + b, hs[2] + c, hs[3] + d,
                  hs[4] + e, hs[5] + f, hs[6] + g, hs[7] + h};
    end
  end

  // Round constant ROM, indexed by the round counter.
  always_comb begin
    case (t[5:0])
      6'd0:  k = 32'h428a2f98;
      6'd1:  k = 32'h71374491;
      6'd2:  k = 32'hb5c0fbcf;
      6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;
      6'd5:  k = 32'h59f111f1;
      6'd6:  k = 32'h923f82a4;
      6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;
      6'd9:  k = 32'h12835b01;
      6'd10: k = 32'h243185be;
      6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;
      6'd13: k = 32'h80deb1fe;
      6'd14: k = 32'h9bdc06a7;
      6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;
      6'd17: k = 32'hefbe4786;
      6'd18: k = 32'h0fc19dc6;
      6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;
      6'd21: k = 32'h4a7484aa;
      6'd22: k = 32'h5cb0a9dc;
      6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;
      6'd25: k = 32'ha831c66d;
      6'd26: k = 32'hb00327c8;
      6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;
      6'd29: k = 32'hd5a79147;
      6'd30: k = 32'h06ca6351;
      6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;
      6'd33: k = 32'h2e1b2138;
      6'd34: k = 32'h4d2c6dfc;
      6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;
      6'd37: k = 32'h766a0abb;
      6'd38: k = 32'h81c2c92e;
      6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;
      6'd41: k = 32'ha81a664b;
      6'd42: k = 32'hc24b8b70;
      6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;
      6'd45: k = 32'hd6990624;
      6'd46: k = 32'hf40e3585;
      6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;
      6'd49: k = 32'h1e376c08;
      6'd50: k = 32'h2748774c;
      6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;
      6'd53: k = 32'h4ed8aa4a;
      6'd54: k = 32'h5b9cca4f;
      6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;
      6'd57: k = 32'h78a5636f;
      6'd58: k = 32'h84c87814;
      6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;
      6'd61: k = 32'ha4506ceb;
      6'd62: k = 32'hbef9a3f7;
      6'd63: k = 32'hc67178f2;
      default: k = '0;
    endcase
  end

endmodule

// File: tb/tb_naive_design.sv
// Directed bench for the iterative SHA-256 compression core.
// Known digests plus a behavioural model for the odd vectors.
module tb_naive_design;

  logic          clk;
  logic          reset;
  logic [255:0]  h_in;
  logic [2047:0] w;
  logic [255:0]  h_out;
  logic          done;

  int checks;
  int failures;

  naive_design dut (
    .clk   (clk),
    .reset (reset),
    .H_in  (h_in),
    .W     (w),
    .H_out (h_out),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_TWO =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [2047:0] expand(input logic [511:0] blk);
    logic [31:0] x [64];
    logic [2047:0] r;
    for (int j = 0; j < 16; j++) x[j] = blk[511-32*j -: 32];
    for (int j = 16; j < 64; j++)
      x[j] = (rotr(x[j-2], 17) ^ rotr(x[j-2], 19) ^ (x[j-2] >> 10))
           + x[j-7]
           + (rotr(x[j-15], 7) ^ rotr(x[j-15], 18) ^ (x[j-15] >> 3))
           + x[j-16];
    for (int j = 0; j < 64; j++) r[2047-32*j -: 32] = x[j];
    return r;
  endfunction

  function automatic logic [255:0] sha_model(input logic [255:0] hv,
                                             input logic [2047:0] wv);
    logic [31:0] v [8];
    logic [31:0] x1, x2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = hv[255-32*i -: 32];
    for (int n = 0; n < 64; n++) begin
      x1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[n] + wv[2047-32*n -: 32];
      x2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + x1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hv[255-32*i -: 32] + v[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 8; i++) h_in[32*i +: 32] = $urandom;
    for (int i = 0; i < 64; i++) w[32*i +: 32] = $urandom;
  endtask

  // Two reset edges, then 64 edges with done low and done/digest on the 65th.
  task automatic run_block(input string tag, input logic [255:0] hv,
                           input logic [2047:0] wv, input logic [255:0] exp);
    h_in  = hv;
    w     = wv;
    reset = 1'b1;
    tick();
    chk({tag, "_rst_done"}, {255'd0, done}, 256'd0);
    chk({tag, "_rst_hout"}, h_out, 256'd0);
    tick();
    chk({tag, "_rst_hold"}, {255'd0, done}, 256'd0);
    reset = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      tick();
      chk({tag, "_latency"}, {255'd0, done}, 256'd0);
    end
    tick();
    chk({tag, "_done"}, {255'd0, done}, 256'd1);
    chk({tag, "_digest"}, h_out, exp);
  endtask

  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h18};
  localparam logic [511:0] B_870   = {32'h87027980, 448'h0, 32'd24};
  localparam logic [511:0] B_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] B_TWO2  = {480'h0, 32'h1c0};

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] chain;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    h_in     = '0;
    w        = '0;

    chk("model_abc", sha_model(IV, expand(B_ABC)), D_ABC);

    run_block("empty", IV, expand(B_EMPTY), D_EMPTY);

    for (int i = 0; i < 100; i++) begin
      randomize_inputs();
      tick();
      chk("hold_hout", h_out, D_EMPTY);
      chk("hold_done", {255'd0, done}, 256'd1);
    end

    run_block("abc", IV, expand(B_ABC), D_ABC);

    run_block("m870279", IV, expand(B_870), sha_model(IV, expand(B_870)));

    randomize_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (30) tick();
    chk("mid_run_done", {255'd0, done}, 256'd0);
    run_block("mid_abc", IV, expand(B_ABC), D_ABC);

    run_block("blk1", IV, expand(B_TWO1), sha_model(IV, expand(B_TWO1)));
    chain = h_out;
    run_block("blk2", chain, expand(B_TWO2), D_TWO);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
